// File: rtl/reg_dump_ctrl.sv
// Debug-read scheduler: freezes the pipeline, borrows register bank
// read port 1 and streams every register to the debug unit.
//
// Ports:
//   clk, reset         clock, async active-high reset
//   i_dump_req         dump request (sampled in IDLE only)
//   i_pipe_empty       no register write pending in EX/MEM/WB
//   i_rf_data          combinational read data of bank port 1
//   i_dump_ready       debug unit accepts current word
//   o_stall_pipe       freeze PC/IF/ID, bubble ID->EX
//   o_rf_sel           port 1 address taken from o_rf_addr
//   o_rf_addr          register index being read
//   o_dump_valid       o_dump_data/o_dump_index valid
//   o_dump_data        captured register value
//   o_dump_index       index of o_dump_data
//   o_dump_done        one-cycle pulse after last word accepted
//   o_busy             high outside IDLE
module reg_dump_ctrl #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_dump_req,
  input  logic                  i_pipe_empty,
  input  logic [31:0]           i_rf_data,
  input  logic                  i_dump_ready,
  output logic                  o_stall_pipe,
  output logic                  o_rf_sel,
  output logic [ADDR_WIDTH-1:0] o_rf_addr,
  output logic                  o_dump_valid,
  output logic [31:0]           o_dump_data,
  output logic [ADDR_WIDTH-1:0] o_dump_index,
  output logic                  o_dump_done,
  output logic                  o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    READ,
    SEND,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(NUM_REGS - 1);

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      o_dump_data  <= '0;
      o_dump_index <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == READ) begin
        o_dump_data  <= i_rf_data;
        o_dump_index <= cnt;
      end
    end
  end

  // Terminal compare happens before the increment, so the
  // counter never wraps past NUM_REGS-1.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (i_dump_req) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end
      end
      DRAIN: begin
        if (i_pipe_empty) state_nx = READ;
      end
      READ: state_nx = SEND;
      SEND: begin
        if (i_dump_ready) begin
          if (cnt == LAST) begin
            state_nx = DONE;
          end else begin
            cnt_nx   = cnt + 1'b1;
            state_nx = READ;
          end
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore outputs; reset forces state to IDLE, so stall drops
  // asynchronously with reset.
  assign o_busy       = (state != IDLE);
  assign o_stall_pipe = (state != IDLE);
  assign o_rf_sel     = (state == READ);
  assign o_rf_addr    = (state == READ) ? cnt : '0;
  assign o_dump_valid = (state == SEND);
  assign o_dump_done  = (state == DONE);

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed bench for reg_dump_ctrl with a register bank model.
// Observation n is taken 1 ns after the n-th edge following the request.
module tb_reg_dump_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_dump_req;
  logic        i_pipe_empty;
  logic [31:0] i_rf_data;
  logic        i_dump_ready;
  logic        o_stall_pipe;
  logic        o_rf_sel;
  logic [4:0]  o_rf_addr;
  logic        o_dump_valid;
  logic [31:0] o_dump_data;
  logic [4:0]  o_dump_index;
  logic        o_dump_done;
  logic        o_busy;

  logic [31:0] rf [32];
  int          vecs = 0;
  int          fails = 0;

  reg_dump_ctrl #(.NUM_REGS(32), .ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_dump_req   (i_dump_req),
    .i_pipe_empty (i_pipe_empty),
    .i_rf_data    (i_rf_data),
    .i_dump_ready (i_dump_ready),
    .o_stall_pipe (o_stall_pipe),
    .o_rf_sel     (o_rf_sel),
    .o_rf_addr    (o_rf_addr),
    .o_dump_valid (o_dump_valid),
    .o_dump_data  (o_dump_data),
    .o_dump_index (o_dump_index),
    .o_dump_done  (o_dump_done),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  always_comb i_rf_data = rf[o_rf_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_dump_req = 1'b0;
    i_pipe_empty = 1'b1;
    i_dump_ready = 1'b1;
    step();
    step();
    vecs++;
    if ({o_stall_pipe, o_rf_sel, o_dump_valid, o_dump_done, o_busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b exp 00000",
        {o_stall_pipe, o_rf_sel, o_dump_valid, o_dump_done, o_busy});
    end
    vecs++;
    if (o_dump_data !== 32'h0 || o_dump_index !== 5'd0 || o_rf_addr !== 5'd0) begin
      fails++;
      $display("FAIL reset_regs got %h/%0d/%0d exp 0/0/0",
        o_dump_data, o_dump_index, o_rf_addr);
    end
    reset = 1'b0;
    step();
    vecs++;
    if (o_busy !== 1'b0 || o_stall_pipe !== 1'b0) begin
      fails++;
      $display("FAIL reset_release busy %b stall %b exp 0 0", o_busy, o_stall_pipe);
    end
  endtask

  task automatic test_basic();
    logic       ev;
    logic       esel;
    logic [4:0] ek;
    i_pipe_empty = 1'b1;
    i_dump_ready = 1'b1;
    i_dump_req = 1'b1;
    step();
    i_dump_req = 1'b0;
    for (int n = 1; n <= 67; n++) begin
      if (n > 1) step();
      ev = (n >= 3 && n <= 65 && n % 2 == 1);
      esel = (n >= 2 && n <= 64 && n % 2 == 0);
      vecs++;
      if (o_dump_valid !== ev) begin
        fails++;
        $display("FAIL basic_valid n=%0d got %b exp %b", n, o_dump_valid, ev);
      end
      if (ev) begin
        ek = 5'((n - 3) / 2);
        vecs++;
        if (o_dump_index !== ek || o_dump_data !== 32'h1000_0000 + 32'(ek)) begin
          fails++;
          $display("FAIL basic_word n=%0d got %0d/%h exp %0d/%h", n,
            o_dump_index, o_dump_data, ek, 32'h1000_0000 + 32'(ek));
        end
      end
      vecs++;
      if (o_rf_sel !== esel) begin
        fails++;
        $display("FAIL basic_rf_sel n=%0d got %b exp %b", n, o_rf_sel, esel);
      end
      if (esel) begin
        vecs++;
        if (o_rf_addr !== 5'((n - 2) / 2)) begin
          fails++;
          $display("FAIL basic_rf_addr n=%0d got %0d exp %0d", n, o_rf_addr, (n - 2) / 2);
        end
      end
      vecs++;
      if (o_dump_done !== (n == 66)) begin
        fails++;
        $display("FAIL basic_done n=%0d got %b exp %b", n, o_dump_done, n == 66);
      end
      vecs++;
      if (o_stall_pipe !== (n <= 66)) begin
        fails++;
        $display("FAIL basic_stall n=%0d got %b exp %b", n, o_stall_pipe, n <= 66);
      end
    end
  endtask

  task automatic test_drain();
    logic       ev;
    logic [4:0] ek;
    i_pipe_empty = 1'b0;
    i_dump_ready = 1'b1;
    i_dump_req = 1'b1;
    step();
    i_dump_req = 1'b0;
    for (int n = 1; n <= 72; n++) begin
      if (n > 1) step();
      ev = (n >= 8 && n <= 70 && n % 2 == 0);
      vecs++;
      if (o_dump_valid !== ev) begin
        fails++;
        $display("FAIL drain_valid n=%0d got %b exp %b", n, o_dump_valid, ev);
      end
      if (ev) begin
        ek = 5'((n - 8) / 2);
        vecs++;
        if (o_dump_index !== ek || o_dump_data !== 32'h1000_0000 + 32'(ek)) begin
          fails++;
          $display("FAIL drain_word n=%0d got %0d/%h exp %0d", n,
            o_dump_index, o_dump_data, ek);
        end
      end
      if (n <= 6) begin
        vecs++;
        if (o_rf_sel !== 1'b0 || o_stall_pipe !== 1'b1) begin
          fails++;
          $display("FAIL drain_hold n=%0d sel %b stall %b exp 0 1", n, o_rf_sel, o_stall_pipe);
        end
      end
      vecs++;
      if (o_dump_done !== (n == 71)) begin
        fails++;
        $display("FAIL drain_done n=%0d got %b exp %b", n, o_dump_done, n == 71);
      end
      // empty stays low for the first five DRAIN cycles
      i_pipe_empty = (n >= 6);
    end
    vecs++;
    if (o_stall_pipe !== 1'b0) begin
      fails++;
      $display("FAIL drain_end stall got %b exp 0", o_stall_pipe);
    end
  endtask

  task automatic test_backpressure();
    logic       ev;
    logic [4:0] ek;
    i_pipe_empty = 1'b1;
    i_dump_ready = 1'b1;
    i_dump_req = 1'b1;
    step();
    i_dump_req = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      if (n > 1) step();
      i_dump_ready = !(n >= 11 && n <= 13);
      if (n < 11) begin
        ev = (n >= 3 && n % 2 == 1);
        ek = 5'((n - 3) / 2);
      end else if (n <= 14) begin
        ev = 1'b1;
        ek = 5'd4;
      end else begin
        ev = (n >= 16 && n <= 68 && n % 2 == 0);
        ek = 5'((n - 6) / 2);
      end
      vecs++;
      if (o_dump_valid !== ev) begin
        fails++;
        $display("FAIL bp_valid n=%0d got %b exp %b", n, o_dump_valid, ev);
      end
      if (ev) begin
        vecs++;
        if (o_dump_index !== ek || o_dump_data !== 32'h1000_0000 + 32'(ek)) begin
          fails++;
          $display("FAIL bp_word n=%0d got %0d/%h exp %0d", n,
            o_dump_index, o_dump_data, ek);
        end
      end
      vecs++;
      if (o_dump_done !== (n == 69)) begin
        fails++;
        $display("FAIL bp_done n=%0d got %b exp %b", n, o_dump_done, n == 69);
      end
    end
    vecs++;
    if (o_busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_end busy got %b exp 0", o_busy);
    end
    i_dump_ready = 1'b1;
  endtask

  task automatic test_busy_req();
    int         words;
    int         dones;
    i_pipe_empty = 1'b1;
    i_dump_ready = 1'b1;
    words = 0;
    dones = 0;
    i_dump_req = 1'b1;
    step();
    i_dump_req = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      if (n > 1) step();
      i_dump_req = (n == 23);
      if (n == 23) begin
        vecs++;
        if (o_dump_valid !== 1'b1 || o_dump_index !== 5'd10) begin
          fails++;
          $display("FAIL busy_at10 valid %b idx %0d exp 1 10", o_dump_valid, o_dump_index);
        end
      end
      if (o_dump_valid && i_dump_ready) begin
        vecs++;
        if (o_dump_index !== 5'(words)) begin
          fails++;
          $display("FAIL busy_seq got %0d exp %0d", o_dump_index, words);
        end
        words++;
      end
      if (o_dump_done) dones++;
    end
    vecs++;
    if (words != 32 || dones != 1) begin
      fails++;
      $display("FAIL busy_count words %0d dones %0d exp 32 1", words, dones);
    end
    vecs++;
    if (o_busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_end busy got %b exp 0", o_busy);
    end
  endtask

  task automatic test_back_to_back();
    i_pipe_empty = 1'b1;
    i_dump_ready = 1'b1;
    i_dump_req = 1'b1;
    step();
    for (int n = 1; n <= 135; n++) begin
      if (n > 1) step();
      if (n == 100) i_dump_req = 1'b0;
      vecs++;
      if (o_dump_done !== (n == 66 || n == 133)) begin
        fails++;
        $display("FAIL b2b_done n=%0d got %b", n, o_dump_done);
      end
      vecs++;
      if (o_stall_pipe !== !(n == 67 || n >= 134)) begin
        fails++;
        $display("FAIL b2b_stall n=%0d got %b exp %b", n, o_stall_pipe,
          !(n == 67 || n >= 134));
      end
      if (n == 70) begin
        vecs++;
        if (o_dump_valid !== 1'b1 || o_dump_index !== 5'd0 ||
            o_dump_data !== 32'h1000_0000) begin
          fails++;
          $display("FAIL b2b_first valid %b idx %0d data %h exp 1 0 10000000",
            o_dump_valid, o_dump_index, o_dump_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    i_pipe_empty = 1'b1;
    i_dump_ready = 1'b0;
    i_dump_req = 1'b1;
    step();
    i_dump_req = 1'b0;
    for (int n = 1; n <= 60 && !found; n++) begin
      if (o_dump_valid && o_dump_index == 5'd7) found = 1'b1;
      else begin
        i_dump_ready = o_dump_valid;
        step();
        i_dump_ready = 1'b0;
      end
    end
    vecs++;
    if (!found) begin
      fails++;
      $display("FAIL rstmid_reach index 7 not seen within 60 cycles");
    end
    #2;
    reset = 1'b1;
    #1;
    vecs++;
    if ({o_stall_pipe, o_rf_sel, o_dump_valid, o_dump_done, o_busy} !== 5'b0) begin
      fails++;
      $display("FAIL rstmid_ctrl got %b exp 00000",
        {o_stall_pipe, o_rf_sel, o_dump_valid, o_dump_done, o_busy});
    end
    vecs++;
    if (o_dump_data !== 32'h0 || o_dump_index !== 5'd0 || o_rf_addr !== 5'd0) begin
      fails++;
      $display("FAIL rstmid_regs got %h/%0d/%0d exp 0/0/0",
        o_dump_data, o_dump_index, o_rf_addr);
    end
    step();
    reset = 1'b0;
    i_dump_ready = 1'b1;
    step();
    vecs++;
    if (o_stall_pipe !== 1'b0 || o_busy !== 1'b0 || o_dump_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_idle stall %b busy %b valid %b exp 0 0 0",
        o_stall_pipe, o_busy, o_dump_valid);
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = 32'h1000_0000 + 32'(k);
    test_reset();
    test_basic();
    test_drain();
    test_backpressure();
    test_busy_req();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
